// File: rtl/md_pkg.sv
// md_pkg: shared op encoding, FSM states and latency defaults for the multiply/divide unit
package md_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;
  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;
  function automatic logic is_md_busy_op(input md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational product/quotient/remainder core with div-by-zero and MIN_INT/-1 flags
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div0,
  output logic             o_ovf
);
  localparam int W = WIDTH;
  logic             w_sgn, w_div, w_na, w_nb;
  logic [2*W-1:0]   w_ax, w_bx, w_prod;
  logic [W-1:0]     w_ua, w_ub, w_den, w_uq, w_ur;
  // Signed ops work on magnitudes; signs are reapplied after the unsigned divide.
  always_comb begin
    w_sgn  = i_op == MD_MULT || i_op == MD_DIV;
    w_div  = i_op == MD_DIV || i_op == MD_DIVU;
    w_na   = w_sgn & i_a[W-1];
    w_nb   = w_sgn & i_b[W-1];
    w_ax   = {{W{w_na}}, i_a};
    w_bx   = {{W{w_nb}}, i_b};
    w_prod = w_ax * w_bx;
    w_ua   = w_na ? -i_a : i_a;
    w_ub   = w_nb ? -i_b : i_b;
    o_div0 = i_b == '0;
    o_ovf  = i_op == MD_DIV && i_a == {1'b1, {(W-1){1'b0}}} && i_b == '1;
    w_den  = o_div0 ? W'(1) : w_ub;
    w_uq   = w_ua / w_den;
    w_ur   = w_ua % w_den;
    o_lo   = !w_div ? w_prod[W-1:0] : (w_na ^ w_nb) ? -w_uq : w_uq;
    o_hi   = !w_div ? w_prod[2*W-1:W] : w_na ? -w_ur : w_ur;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit with private HI/LO, busy stall output and MFHI/MFLO read port
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_md_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_rd_hi,
  output logic [WIDTH-1:0] o_mf_out,
  output logic             o_busy
);
  localparam int MAX_LAT = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  md_op_e           w_op;
  md_state_e        r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo, w_hi, w_lo;
  logic             r_pend_ok, w_div0, w_ovf, w_go, w_done, w_is_div, w_idle_start;
  assign w_op = md_op_e'(i_md_op);
  md_calc #(.WIDTH(WIDTH)) u_calc (
    .i_op  (w_op),
    .i_a   (i_rs_val),
    .i_b   (i_rt_val),
    .o_hi  (w_hi),
    .o_lo  (w_lo),
    .o_div0(w_div0),
    .o_ovf (w_ovf)
  );
  // Next state, launch/complete strobes and the read mux; starts while busy are ignored.
  always_comb begin
    w_idle_start = r_state == ST_IDLE && i_start;
    w_go         = w_idle_start && is_md_busy_op(w_op);
    w_is_div     = w_op == MD_DIV || w_op == MD_DIVU;
    w_done       = r_state == ST_RUN && r_cnt == CW'(1);
    w_next       = w_go ? ST_RUN : w_done ? ST_IDLE : r_state;
    o_busy       = r_state == ST_RUN;
    o_mf_out     = i_rd_hi ? r_hi : r_lo;
  end
  // State register; reset aborts an op in flight.
  always_ff @(posedge i_clk) begin
    r_state <= i_reset ? ST_IDLE : w_next;
  end
  // Result capture at launch, latency countdown, and HI/LO commit or MTHI/MTLO write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_pend_ok <= 1'b0;
    end else begin
      if (w_go) begin
        r_cnt     <= w_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        r_pend_hi <= w_ovf ? '0 : w_hi;
        r_pend_lo <= w_ovf ? i_rs_val : w_lo;
        r_pend_ok <= !(w_is_div && w_div0);
      end else if (o_busy) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done && r_pend_ok) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else if (w_idle_start && w_op == MD_MTHI) begin
        r_hi <= i_rs_val;
      end else if (w_idle_start && w_op == MD_MTLO) begin
        r_lo <= i_rs_val;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against a cycle-indexed reference model
module tb_md_unit;
  import md_pkg::*;
  logic        clk = 1'b0;
  logic        i_reset, i_start, i_rd_hi;
  logic [2:0]  i_md_op;
  logic [31:0] i_rs_val, i_rt_val, o_mf_out;
  logic        o_busy;
  int          n_chk = 0, n_err = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_ok, m_busy;
  int          cyc, end_cyc;
  always #5 clk = ~clk;
  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_md_op (i_md_op),
    .i_rs_val(i_rs_val),
    .i_rt_val(i_rt_val),
    .i_rd_hi (i_rd_hi),
    .o_mf_out(o_mf_out),
    .o_busy  (o_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic ok);
    longint     sp;
    logic [63:0] up;
    int         sa, sb;
    ok = 1'b1;
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      MD_DIV: begin
        if (b == 0) ok = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = a;
          hi = 0;
        end else begin
          sa = a;
          sb = b;
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b == 0) ok = 1'b0;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ok = 1'b0;
    endcase
  endfunction
  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic rd);
    i_reset  = rst;
    i_start  = st;
    i_md_op  = op;
    i_rs_val = rs;
    i_rt_val = rt;
    i_rd_hi  = rd;
    @(posedge clk);
    if (rst) begin
      m_hi    = '0;
      m_lo    = '0;
      end_cyc = -1;
    end else if (cyc <= end_cyc) begin
      if (cyc == end_cyc && p_ok) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (st) begin
      if (op == MD_MULT || op == MD_MULTU) begin
        ref_op(op, rs, rt, p_hi, p_lo, p_ok);
        end_cyc = cyc + 5;
      end else if (op == MD_DIV || op == MD_DIVU) begin
        ref_op(op, rs, rt, p_hi, p_lo, p_ok);
        end_cyc = cyc + 10;
      end else if (op == MD_MTHI) m_hi = rs;
      else if (op == MD_MTLO) m_lo = rs;
    end
    cyc++;
    m_busy = cyc <= end_cyc;
    #1;
    check("busy", {31'b0, o_busy}, {31'b0, m_busy});
    check("mf_out", o_mf_out, rd ? m_hi : m_lo);
  endtask
  task automatic idle(input logic rd);
    step(1'b0, 1'b0, 3'(MD_NONE), 32'h0, 32'h0, rd);
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    step(1'b0, 1'b1, op, rs, rt, 1'b0);
    check("busy_first", {31'b0, o_busy}, 32'd1);
    for (int i = 0; i < lat - 1; i++) begin
      idle(1'b0);
      check("busy_hold", {31'b0, o_busy}, 32'd1);
    end
    idle(1'b1);
    check("busy_end", {31'b0, o_busy}, 32'd0);
    check("hi_const", o_mf_out, ehi);
    idle(1'b0);
    check("lo_const", o_mf_out, elo);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction
  initial begin
    cyc     = 0;
    end_cyc = -1;
    m_hi    = '0;
    m_lo    = '0;
    p_hi    = '0;
    p_lo    = '0;
    p_ok    = 1'b0;
    step(1'b1, 1'b0, 3'(MD_NONE), 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 3'(MD_MULT), 32'h5, 32'h7, 1'b0);
    check("reset_busy", {31'b0, o_busy}, 32'd0);
    check("reset_lo", o_mf_out, 32'h0);
    run_op(3'(MD_MULT), 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op(3'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3'(MD_DIVU), 32'd7, 32'd2, 10, 32'd1, 32'd3);
    step(1'b0, 1'b1, 3'(MD_MTHI), 32'h11, 32'h0, 1'b1);
    step(1'b0, 1'b1, 3'(MD_MTLO), 32'h22, 32'h0, 1'b1);
    check("mthi", o_mf_out, 32'h11);
    run_op(3'(MD_DIV), 32'h1234, 32'd0, 10, 32'h11, 32'h22);
    run_op(3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    step(1'b0, 1'b1, 3'(MD_MULT), 32'd3, 32'd4, 1'b0);
    step(1'b0, 1'b1, 3'(MD_MULT), 32'd5, 32'd6, 1'b0);
    step(1'b0, 1'b1, 3'(MD_MTHI), 32'hAB, 32'd0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("ign_busy", {31'b0, o_busy}, 32'd1);
    idle(1'b1);
    check("ign_done", {31'b0, o_busy}, 32'd0);
    check("ign_hi", o_mf_out, 32'h0);
    idle(1'b0);
    check("ign_lo", o_mf_out, 32'd12);
    run_op(3'(MD_DIVU), 32'd100, 32'd7, 10, 32'd2, 32'd14);
    step(1'b0, 1'b1, 3'(MD_DIV), 32'd50, 32'd3, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 3'(MD_NONE), 32'h0, 32'h0, 1'b1);
    check("abort_busy", {31'b0, o_busy}, 32'd0);
    check("abort_hi", o_mf_out, 32'h0);
    for (int i = 0; i < 10; i++) begin
      idle(1'(i));
      check("abort_hold", o_mf_out, 32'h0);
    end
    step(1'b0, 1'b1, 3'(MD_MTLO), 32'h5A, 32'h0, 1'b1);
    check("mtlo_busy", {31'b0, o_busy}, 32'd0);
    idle(1'b0);
    check("mtlo_lo", o_mf_out, 32'h5A);
    check("mtlo_busy2", {31'b0, o_busy}, 32'd0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 6)), pick(), pick(), 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
